fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: streams 16-bit words from memory into registered
// decoder-side outputs. Define FETCH_SKID_BUFFER_EN to add a one-entry skid buffer.
module fetch_stage #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_out,
  output logic [15:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [15:0] mem_data_in,
  input  logic        stall_in,
  input  logic        branch_in,
  input  logic [15:0] branch_addr_in,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out
);

  localparam logic [15:0] START_PC = RESET_VECTOR & 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE,
    REQ
`ifdef FETCH_SKID_BUFFER_EN
    , HOLD
`endif
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic        drop;

`ifdef FETCH_SKID_BUFFER_EN
  logic [15:0] buf_instr;
  logic [15:0] buf_pc;
`endif

  logic [15:0] branch_tgt;
  logic [15:0] next_addr;
  logic        ack_hit;
  logic        accept;

  assign branch_tgt = branch_addr_in & 16'hFFFE;
  assign next_addr  = mem_addr_out + 16'd2;
  assign ack_hit    = mem_req_out && mem_ack_in;
  // The output register can take a word unless it holds one the decoder refuses.
  assign accept     = !valid_out || !stall_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_req_out  <= 1'b0;
      mem_addr_out <= START_PC;
      pc           <= START_PC;
      drop         <= 1'b0;
      instr_out    <= 16'h0000;
      pc_out       <= START_PC;
      valid_out    <= 1'b0;
`ifdef FETCH_SKID_BUFFER_EN
      buf_instr    <= 16'h0000;
      buf_pc       <= START_PC;
`endif
    end else if (branch_in) begin
      // An unacked request must finish at its old address; its data is dropped.
      state     <= REQ;
      valid_out <= 1'b0;
      pc        <= branch_tgt;
      if (mem_req_out && !mem_ack_in) begin
        drop <= 1'b1;
      end else begin
        drop         <= 1'b0;
        mem_req_out  <= 1'b1;
        mem_addr_out <= branch_tgt;
      end
    end else begin
      case (state)
        IDLE: begin
          state        <= REQ;
          mem_req_out  <= 1'b1;
          mem_addr_out <= pc;
        end

        REQ: begin
          // NOTE: non-blocking assignments resolve last-wins, so this default
          // clear is safely overridden by a load further down in the same cycle.
          if (!stall_in) valid_out <= 1'b0;
          if (ack_hit) begin
            if (drop) begin
              drop         <= 1'b0;
              mem_addr_out <= pc;
            end else if (accept) begin
              instr_out    <= mem_data_in;
              pc_out       <= mem_addr_out;
              valid_out    <= 1'b1;
              pc           <= next_addr;
              mem_addr_out <= next_addr;
            end else begin
`ifdef FETCH_SKID_BUFFER_EN
              buf_instr    <= mem_data_in;
              buf_pc       <= mem_addr_out;
              pc           <= next_addr;
              mem_addr_out <= next_addr;
              state        <= HOLD;
`endif
              // Without a buffer the word is discarded and refetched after the stall.
              mem_req_out  <= 1'b0;
            end
          end else if (!mem_req_out && accept) begin
            mem_req_out <= 1'b1;
          end
        end

`ifdef FETCH_SKID_BUFFER_EN
        HOLD: begin
          if (!stall_in) begin
            instr_out   <= buf_instr;
            pc_out      <= buf_pc;
            valid_out   <= 1'b1;
            mem_req_out <= 1'b1;
            state       <= REQ;
          end
        end
`endif

        default: begin
          state       <= IDLE;
          mem_req_out <= 1'b0;
          valid_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; memory model returns addr + 16'h1000
// after a programmable number of wait cycles.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_out;
  logic [15:0] mem_addr_out;
  logic        mem_ack_in;
  logic [15:0] mem_data_in;
  logic        stall_in;
  logic        branch_in;
  logic [15:0] branch_addr_in;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  int   mem_lat  = 0;
  int   wait_cnt = 0;
  logic ack_force = 1'b0;

`ifdef FETCH_SKID_BUFFER_EN
  localparam int MAX_SPAN = 3;
`else
  localparam int MAX_SPAN = 4;
`endif

  fetch_stage #(.RESET_VECTOR(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_ack_in     (mem_ack_in),
    .mem_data_in    (mem_data_in),
    .stall_in       (stall_in),
    .branch_in      (branch_in),
    .branch_addr_in (branch_addr_in),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out)
  );

  always #5 clk = ~clk;

  assign mem_ack_in  = (mem_req_out && (wait_cnt >= mem_lat)) || ack_force;
  assign mem_data_in = ack_force ? 16'hDEAD : mem_addr_out + 16'h1000;

  always @(posedge clk) begin
    if (!mem_req_out || mem_ack_in) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    mem_lat        = lat;
    rst            = 1'b1;
    stall_in       = 1'b0;
    branch_in      = 1'b0;
    branch_addr_in = 16'h0000;
    ack_force      = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    do_reset(0);
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_tests++; if (mem_req_out !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req_out); end
    n_tests++; if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instr_out); end
    n_tests++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", pc_out); end
  endtask

  task automatic test_stream;
    rst = 1'b0;
    tick();
    n_tests++; if (mem_req_out !== 1'b1 || mem_addr_out !== 16'h0000) begin n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=0000", mem_req_out, mem_addr_out); end
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stream_cycle1_valid: got %b expected 0", valid_out); end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (valid_out !== 1'b1 || pc_out !== 16'(2 * i) || instr_out !== 16'(16'h1000 + 2 * i)) begin
        n_fail++;
        $display("FAIL stream_word%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, valid_out, pc_out, instr_out, 16'(2 * i), 16'(16'h1000 + 2 * i));
      end
      n_tests++; if (mem_addr_out[0] !== 1'b0) begin n_fail++; $display("FAIL stream_addr_lsb: got %h expected even", mem_addr_out); end
      tick();
    end
  endtask

  task automatic test_stall;
    logic [15:0] got_pc [3];
    logic [15:0] got_in [3];
    int n_got = 0;
    int span  = 0;
    bit found = 0;
    do_reset(0);
    rst = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (valid_out === 1'b1 && pc_out === 16'h0004) found = 1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL stall_reach_1004: got pc=%h expected 0004 within 10 cycles", pc_out); end
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (valid_out !== 1'b1 || instr_out !== 16'h1004 || pc_out !== 16'h0004) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h expected v=1 pc=0004 instr=1004", i, valid_out, pc_out, instr_out);
      end
      if (i >= 1) begin
        n_tests++; if (mem_req_out !== 1'b0) begin n_fail++; $display("FAIL stall_no_req%0d: got %b expected 0", i, mem_req_out); end
      end
    end
    stall_in = 1'b0;
    for (int i = 0; i < 8 && n_got < 3; i++) begin
      if (valid_out === 1'b1) begin
        got_pc[n_got] = pc_out;
        got_in[n_got] = instr_out;
        n_got++;
      end
      span++;
      tick();
    end
    n_tests++; if (n_got !== 3) begin n_fail++; $display("FAIL stall_release_count: got %0d expected 3", n_got); end
    for (int k = 0; k < 3 && k < n_got; k++) begin
      n_tests++;
      if (got_pc[k] !== 16'(4 + 2 * k) || got_in[k] !== 16'(16'h1004 + 2 * k)) begin
        n_fail++;
        $display("FAIL stall_release_seq%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                 k, got_pc[k], got_in[k], 16'(4 + 2 * k), 16'(16'h1004 + 2 * k));
      end
    end
    n_tests++; if (span > MAX_SPAN) begin n_fail++; $display("FAIL stall_release_span: got %0d expected at most %0d", span, MAX_SPAN); end
  endtask

  task automatic test_branch_pending;
    bit found = 0;
    do_reset(3);
    rst = 1'b0;
    tick();
    branch_in      = 1'b1;
    branch_addr_in = 16'h2001;
    tick();
    branch_in = 1'b0;
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL branch_pend_valid: got %b expected 0", valid_out); end
    n_tests++; if (mem_req_out !== 1'b1 || mem_addr_out !== 16'h0000) begin n_fail++; $display("FAIL branch_pend_req_stable: got req=%b addr=%h expected req=1 addr=0000", mem_req_out, mem_addr_out); end
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (valid_out === 1'b1) found = 1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL branch_pend_timeout: got no valid word expected one within 20 cycles"); end
    n_tests++;
    if (pc_out !== 16'h2000 || instr_out !== 16'h3000) begin
      n_fail++;
      $display("FAIL branch_pend_target: got pc=%h instr=%h expected pc=2000 instr=3000", pc_out, instr_out);
    end
  endtask

  task automatic test_wrap;
    do_reset(0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    branch_in      = 1'b1;
    branch_addr_in = 16'hFFFF;
    tick();
    branch_in = 1'b0;
    n_tests++; if (valid_out !== 1'b0 || mem_addr_out !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_branch: got v=%b addr=%h expected v=0 addr=FFFE", valid_out, mem_addr_out); end
    tick();
    n_tests++; if (valid_out !== 1'b1 || pc_out !== 16'hFFFE || instr_out !== 16'h0FFE) begin n_fail++; $display("FAIL wrap_fffe: got v=%b pc=%h instr=%h expected v=1 pc=FFFE instr=0FFE", valid_out, pc_out, instr_out); end
    tick();
    n_tests++; if (valid_out !== 1'b1 || pc_out !== 16'h0000 || instr_out !== 16'h1000) begin n_fail++; $display("FAIL wrap_0000: got v=%b pc=%h instr=%h expected v=1 pc=0000 instr=1000", valid_out, pc_out, instr_out); end
    tick();
    n_tests++; if (pc_out !== 16'h0002) begin n_fail++; $display("FAIL wrap_0002: got %h expected 0002", pc_out); end
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    do_reset(3);
    rst = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (valid_out === 1'b1) found = 1;
    end
    n_tests++; if (!found || pc_out !== 16'h0000) begin n_fail++; $display("FAIL rstmid_first_word: got v=%b pc=%h expected v=1 pc=0000", valid_out, pc_out); end
    rst       = 1'b1;
    ack_force = 1'b1;
    tick();
    n_tests++;
    if (valid_out !== 1'b0 || mem_req_out !== 1'b0 || instr_out !== 16'h0000 || pc_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got v=%b req=%b instr=%h pc=%h expected v=0 req=0 instr=0000 pc=0000",
               valid_out, mem_req_out, instr_out, pc_out);
    end
    rst = 1'b0;
    tick();
    ack_force = 1'b0;
    n_tests++; if (valid_out !== 1'b0 || mem_req_out !== 1'b1 || mem_addr_out !== 16'h0000) begin n_fail++; $display("FAIL rstmid_late_ack: got v=%b req=%b addr=%h expected v=0 req=1 addr=0000", valid_out, mem_req_out, mem_addr_out); end
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (valid_out === 1'b1) found = 1;
    end
    n_tests++; if (!found || pc_out !== 16'h0000 || instr_out !== 16'h1000) begin n_fail++; $display("FAIL rstmid_refetch: got v=%b pc=%h instr=%h expected v=1 pc=0000 instr=1000", valid_out, pc_out, instr_out); end
  endtask

  task automatic test_branch_stall;
    do_reset(0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    stall_in = 1'b1;
    tick();
    branch_in      = 1'b1;
    branch_addr_in = 16'h0400;
    tick();
    branch_in = 1'b0;
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL brstall_valid: got %b expected 0", valid_out); end
    n_tests++; if (mem_req_out !== 1'b1 || mem_addr_out !== 16'h0400) begin n_fail++; $display("FAIL brstall_req: got req=%b addr=%h expected req=1 addr=0400", mem_req_out, mem_addr_out); end
    stall_in = 1'b0;
    tick();
    n_tests++; if (valid_out !== 1'b1 || pc_out !== 16'h0400 || instr_out !== 16'h1400) begin n_fail++; $display("FAIL brstall_target: got v=%b pc=%h instr=%h expected v=1 pc=0400 instr=1400", valid_out, pc_out, instr_out); end
    tick();
    n_tests++; if (valid_out !== 1'b1 || pc_out !== 16'h0402) begin n_fail++; $display("FAIL brstall_next: got v=%b pc=%h expected v=1 pc=0402", valid_out, pc_out); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_pending();
    test_wrap();
    test_reset_mid();
    test_branch_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
